// File: rtl/mandel_scan_sequencer.sv
// Raster-order pixel scanner feeding the fractal iteration core.
// Walks an H_RES x V_RES grid, offers each pixel's complex coordinate to
// the core over a valid/ready handshake, waits for the iteration count and
// writes it to the frame buffer at the pixel's linear address. Exactly one
// pixel is in flight at any time.
module mandel_scan_sequencer #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int COORD_W = 16,
   parameter int ITER_W  = 8,
   parameter int ADDR_W  = 19
) (
   input  logic               Clk_100M,
   input  logic               Reset_n,
   input  logic               start,
   input  logic [COORD_W-1:0] startX,
   input  logic [COORD_W-1:0] startY,
   input  logic [COORD_W-1:0] stepX,
   input  logic [COORD_W-1:0] stepY,
   output logic               busy,
   output logic               done,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_re,
   output logic [COORD_W-1:0] pix_im,
   input  logic               res_valid,
   input  logic [ITER_W-1:0]  res_iter,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [ITER_W-1:0]  fb_data
);

   localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      WRITE,
      FIN
   } stateType;

   stateType state;
   stateType nextState;

   // Frame parameters captured at start. The imaginary start value is not
   // kept separately: pix_im is loaded from it once and only ever advances.
   logic [COORD_W-1:0] startXReg;
   logic [COORD_W-1:0] stepXReg;
   logic [COORD_W-1:0] stepYReg;

   logic [X_W-1:0]    xCnt;
   logic [Y_W-1:0]    yCnt;
   logic [ADDR_W-1:0] addrCnt;

   logic lastInLine;
   logic lastLine;
   logic startAccept;
   logic issueHandshake;
   logic resultAccept;

   assign lastInLine     = (xCnt == X_LAST);
   assign lastLine       = (yCnt == Y_LAST);
   assign startAccept    = (state == IDLE) && start;
   assign issueHandshake = (state == ISSUE) && pix_ready;
   assign resultAccept   = (state == WAIT) && res_valid;

   // Handshake and status strobes decode straight from the state register so
   // they follow an asynchronous reset with no extra cycle.
   assign pix_valid = (state == ISSUE);
   assign fb_we     = (state == WRITE);
   assign done      = (state == FIN);
   assign busy      = (state == ISSUE) || (state == WAIT) || (state == WRITE);

   // State register; reset drops any frame in progress straight back to IDLE.
   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode. A result only counts once the coordinate has been
   // handed over, so res_valid is looked at in WAIT alone.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (pix_ready) begin
               nextState = WAIT;
            end
         end
         WAIT: begin
            if (res_valid) begin
               nextState = WRITE;
            end
         end
         WRITE: begin
            if (lastInLine && lastLine) begin
               nextState = FIN;
            end else begin
               nextState = ISSUE;
            end
         end
         FIN: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Capture the frame setup once per frame so later input changes are inert.
   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         startXReg <= '0;
         stepXReg  <= '0;
         stepYReg  <= '0;
      end else if (startAccept) begin
         startXReg <= startX;
         stepXReg  <= stepX;
         stepYReg  <= stepY;
      end
   end

   // Pixel position counters and the running linear address, advanced after
   // each write; the address simply counts so no y*H_RES product is needed.
   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         xCnt    <= '0;
         yCnt    <= '0;
         addrCnt <= '0;
      end else if (startAccept) begin
         xCnt    <= '0;
         yCnt    <= '0;
         addrCnt <= '0;
      end else if (state == WRITE) begin
         if (!lastInLine) begin
            xCnt    <= xCnt + X_W'(1);
            addrCnt <= addrCnt + ADDR_W'(1);
         end else if (!lastLine) begin
            xCnt    <= '0;
            yCnt    <= yCnt + Y_W'(1);
            addrCnt <= addrCnt + ADDR_W'(1);
         end
      end
   end

   // Complex coordinate of the current pixel; adds wrap modulo 2^COORD_W.
   // The coordinate only moves in WRITE, so it is stable for the whole offer.
   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_re <= '0;
         pix_im <= '0;
      end else if (startAccept) begin
         pix_re <= startX;
         pix_im <= startY;
      end else if (state == WRITE) begin
         if (!lastInLine) begin
            pix_re <= pix_re + stepXReg;
         end else if (!lastLine) begin
            pix_re <= startXReg;
            pix_im <= pix_im + stepYReg;
         end
      end
   end

   // Frame buffer address/data are loaded with the result and held through
   // the single WRITE cycle that strobes them out.
   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         fb_addr <= '0;
         fb_data <= '0;
      end else if (resultAccept) begin
         fb_addr <= addrCnt;
         fb_data <= res_iter;
      end
   end

   // The handshake term is only informational for the state decode above;
   // keeping it named documents where the coordinate changes ownership.
   logic unusedHandshake;
   assign unusedHandshake = issueHandshake;

endmodule

// File: tb/tb_mandel_scan_sequencer.sv
// Directed bench for mandel_scan_sequencer on a 4x3 grid with a small
// iteration-core model that answers addr+5 two cycles after each accept.
module tb_mandel_scan_sequencer;

   localparam int H_RES   = 4;
   localparam int V_RES   = 3;
   localparam int COORD_W = 16;
   localparam int ITER_W  = 8;
   localparam int ADDR_W  = 19;
   localparam int NPIX    = H_RES * V_RES;

   logic               Clk_100M = 1'b0;
   logic               Reset_n;
   logic               start;
   logic [COORD_W-1:0] startX;
   logic [COORD_W-1:0] startY;
   logic [COORD_W-1:0] stepX;
   logic [COORD_W-1:0] stepY;
   logic               busy;
   logic               done;
   logic               pix_valid;
   logic               pix_ready;
   logic [COORD_W-1:0] pix_re;
   logic [COORD_W-1:0] pix_im;
   logic               res_valid;
   logic [ITER_W-1:0]  res_iter;
   logic               fb_we;
   logic [ADDR_W-1:0]  fb_addr;
   logic [ITER_W-1:0]  fb_data;

   mandel_scan_sequencer #(
      .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W), .ITER_W(ITER_W), .ADDR_W(ADDR_W)
   ) dut (
      .Clk_100M(Clk_100M), .Reset_n(Reset_n), .start(start),
      .startX(startX), .startY(startY), .stepX(stepX), .stepY(stepY),
      .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_re(pix_re), .pix_im(pix_im), .res_valid(res_valid), .res_iter(res_iter),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
   );

   always #5 Clk_100M = ~Clk_100M;

   typedef struct {
      int          pixel;
      logic [15:0] expRe;
      logic [15:0] expIm;
      logic [18:0] expAddr;
      logic [7:0]  expData;
   } vecT;

   vecT baseTable[NPIX];
   vecT wrapTable[NPIX];

   int vecCount  = 0;
   int missCount = 0;

   logic [31:0] accRe[16];
   logic [31:0] accIm[16];
   logic [31:0] wrAddr[16];
   logic [31:0] wrData[16];
   int accCnt, wrCnt, doneCnt;
   bit finished, aborted;

   int stallPixel, stallLen, abortPixel;
   bit spurMode, disturbMode;

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, idx, actual, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "Busy"},   0, 32'(busy),      0);
      checkOutput({tag, "Done"},   0, 32'(done),      0);
      checkOutput({tag, "Valid"},  0, 32'(pix_valid), 0);
      checkOutput({tag, "We"},     0, 32'(fb_we),     0);
      checkOutput({tag, "Re"},     0, 32'(pix_re),    0);
      checkOutput({tag, "Im"},     0, 32'(pix_im),    0);
      checkOutput({tag, "Addr"},   0, 32'(fb_addr),   0);
      checkOutput({tag, "Data"},   0, 32'(fb_data),   0);
   endtask

   task automatic applyStimulus(input logic [15:0] sx, input logic [15:0] sy,
                                input logic [15:0] stx, input logic [15:0] sty);
      startX = sx;
      startY = sy;
      stepX  = stx;
      stepY  = sty;
   endtask

   // Drives one frame cycle by cycle at the falling edge, playing the core.
   task automatic runFrame(input int maxCycles);
      int  d;
      int  stallLeft;
      bit  stallStarted;
      int  postDone;
      int  pendAddr;
      accCnt = 0; wrCnt = 0; doneCnt = 0; finished = 0; aborted = 0;
      d = 0; stallLeft = stallLen; stallStarted = 0; postDone = 0; pendAddr = 0;
      for (int cyc = 0; cyc < maxCycles; cyc++) begin
         @(negedge Clk_100M);
         if (fb_we) begin
            if (wrCnt < 16) begin
               wrAddr[wrCnt] = 32'(fb_addr);
               wrData[wrCnt] = 32'(fb_data);
            end
            wrCnt++;
         end
         if (done) doneCnt++;
         if (postDone > 0) begin
            checkOutput("idleBusy",  postDone, 32'(busy),      0);
            checkOutput("idleValid", postDone, 32'(pix_valid), 0);
         end
         if (postDone == 3) begin
            finished = 1;
            break;
         end
         if (doneCnt > 0) postDone++;

         start = (cyc == 0) || (disturbMode && (cyc == 20 || done));
         if (disturbMode && cyc == 1) begin
            startX = 16'h2222;
            stepX  = 16'h0700;
            stepY  = 16'h0030;
         end
         res_valid = 1'b0;
         res_iter  = '0;
         if (d > 0) begin
            d--;
            if (d == 0) begin
               res_valid = 1'b1;
               res_iter  = ITER_W'(pendAddr + 5);
            end
         end
         if (abortPixel >= 0 && accCnt == abortPixel + 1 && d == 1) begin
            Reset_n   = 1'b0;
            res_valid = 1'b0;
            #1;
            checkResetValues("abort");
            aborted = 1;
            break;
         end
         pix_ready = !(accCnt == stallPixel && stallLeft > 0);
         if (accCnt == stallPixel && stallLeft > 0 && (stallStarted || pix_valid)) begin
            stallStarted = 1;
            checkOutput("stallValid", stallLeft, 32'(pix_valid), 1);
            checkOutput("stallRe",    stallLeft, 32'(pix_re),    32'h1200);
            if (spurMode) begin
               res_valid = 1'b1;
               res_iter  = 8'hAA;
            end
            stallLeft--;
         end
         if (pix_valid && pix_ready) begin
            if (accCnt < 16) begin
               accRe[accCnt] = 32'(pix_re);
               accIm[accCnt] = 32'(pix_im);
            end
            pendAddr = accCnt;
            accCnt++;
            d = 2;
            if (spurMode) begin
               res_valid = 1'b1;
               res_iter  = 8'hEE;
            end
         end
      end
      start     = 1'b0;
      res_valid = 1'b0;
      pix_ready = 1'b1;
   endtask

   task automatic checkFrame(input bit useWrap);
      vecT v;
      checkOutput("frameDone",   0, 32'(finished), 1);
      checkOutput("doneCount",   0, 32'(doneCnt),  1);
      checkOutput("writeCount",  0, 32'(wrCnt),    NPIX);
      checkOutput("acceptCount", 0, 32'(accCnt),   NPIX);
      for (int i = 0; i < NPIX; i++) begin
         v = useWrap ? wrapTable[i] : baseTable[i];
         checkOutput("pixRe",  v.pixel, accRe[i],  32'(v.expRe));
         checkOutput("pixIm",  v.pixel, accIm[i],  32'(v.expIm));
         checkOutput("fbAddr", v.pixel, wrAddr[i], 32'(v.expAddr));
         checkOutput("fbData", v.pixel, wrData[i], 32'(v.expData));
      end
   endtask

   initial begin
      Reset_n = 1'b1; start = 1'b0; pix_ready = 1'b0; res_valid = 1'b0; res_iter = '0;
      startX = '0; startY = '0; stepX = '0; stepY = '0;
      stallPixel = -1; stallLen = 0; abortPixel = -1; spurMode = 0; disturbMode = 0;

      baseTable[0]  = '{0,  16'h1000, 16'hF000, 19'd0,  8'd5};
      baseTable[1]  = '{1,  16'h1100, 16'hF000, 19'd1,  8'd6};
      baseTable[2]  = '{2,  16'h1200, 16'hF000, 19'd2,  8'd7};
      baseTable[3]  = '{3,  16'h1300, 16'hF000, 19'd3,  8'd8};
      baseTable[4]  = '{4,  16'h1000, 16'hF200, 19'd4,  8'd9};
      baseTable[5]  = '{5,  16'h1100, 16'hF200, 19'd5,  8'd10};
      baseTable[6]  = '{6,  16'h1200, 16'hF200, 19'd6,  8'd11};
      baseTable[7]  = '{7,  16'h1300, 16'hF200, 19'd7,  8'd12};
      baseTable[8]  = '{8,  16'h1000, 16'hF400, 19'd8,  8'd13};
      baseTable[9]  = '{9,  16'h1100, 16'hF400, 19'd9,  8'd14};
      baseTable[10] = '{10, 16'h1200, 16'hF400, 19'd10, 8'd15};
      baseTable[11] = '{11, 16'h1300, 16'hF400, 19'd11, 8'd16};

      wrapTable[0]  = '{0,  16'h7F00, 16'h0000, 19'd0,  8'd5};
      wrapTable[1]  = '{1,  16'h8000, 16'h0000, 19'd1,  8'd6};
      wrapTable[2]  = '{2,  16'h8100, 16'h0000, 19'd2,  8'd7};
      wrapTable[3]  = '{3,  16'h8200, 16'h0000, 19'd3,  8'd8};
      wrapTable[4]  = '{4,  16'h7F00, 16'h0200, 19'd4,  8'd9};
      wrapTable[5]  = '{5,  16'h8000, 16'h0200, 19'd5,  8'd10};
      wrapTable[6]  = '{6,  16'h8100, 16'h0200, 19'd6,  8'd11};
      wrapTable[7]  = '{7,  16'h8200, 16'h0200, 19'd7,  8'd12};
      wrapTable[8]  = '{8,  16'h7F00, 16'h0400, 19'd8,  8'd13};
      wrapTable[9]  = '{9,  16'h8000, 16'h0400, 19'd9,  8'd14};
      wrapTable[10] = '{10, 16'h8100, 16'h0400, 19'd10, 8'd15};
      wrapTable[11] = '{11, 16'h8200, 16'h0400, 19'd11, 8'd16};

      #2 Reset_n = 1'b0;
      repeat (3) @(negedge Clk_100M);
      checkResetValues("reset");
      Reset_n = 1'b1;

      $display("[TB] spurious result while idle");
      @(negedge Clk_100M);
      res_valid = 1'b1; res_iter = 8'h55; pix_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk_100M);
         checkOutput("idleSpurWe",    i, 32'(fb_we),     0);
         checkOutput("idleSpurBusy",  i, 32'(busy),      0);
         checkOutput("idleSpurValid", i, 32'(pix_valid), 0);
      end
      res_valid = 1'b0;

      $display("[TB] base frame with back-pressure and spurious results");
      applyStimulus(16'h1000, 16'hF000, 16'h0100, 16'h0200);
      stallPixel = 2; stallLen = 5; spurMode = 1;
      runFrame(400);
      checkFrame(0);
      stallPixel = -1; stallLen = 0; spurMode = 0;

      $display("[TB] coordinate wrap frame");
      applyStimulus(16'h7F00, 16'h0000, 16'h0100, 16'h0200);
      runFrame(400);
      checkFrame(1);

      $display("[TB] start while busy and inputs changed mid-frame");
      applyStimulus(16'h1000, 16'hF000, 16'h0100, 16'h0200);
      disturbMode = 1;
      runFrame(400);
      checkFrame(0);
      disturbMode = 0;

      $display("[TB] reset during WAIT of pixel 6");
      applyStimulus(16'h1000, 16'hF000, 16'h0100, 16'h0200);
      abortPixel = 6;
      runFrame(400);
      checkOutput("aborted",     0, 32'(aborted), 1);
      checkOutput("abortWrites", 0, 32'(wrCnt),   6);
      checkOutput("abortDones",  0, 32'(doneCnt), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk_100M);
         checkOutput("resetHeldWe",   i, 32'(fb_we), 0);
         checkOutput("resetHeldDone", i, 32'(done),  0);
      end
      Reset_n = 1'b1;
      abortPixel = -1;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk_100M);
         checkOutput("postResetWe",   i, 32'(fb_we), 0);
         checkOutput("postResetBusy", i, 32'(busy),  0);
      end
      runFrame(400);
      checkFrame(0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
